bus_dispatch_fifo: RTL and testbench

BUS_DISPATCH_FIFO -- requirements
Module: bus_dispatch_fifo

---
 rtl/bus_dispatch_pkg.sv | 18 +
 rtl/bus_dispatch_mem.sv | 32 +++
 rtl/bus_dispatch_fifo.sv | 137 +++++++++++++
 tb/tb_bus_dispatch_fifo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bus_dispatch_pkg.sv
// rtl/bus_dispatch_pkg.sv - shared constants and helpers for the bus dispatch FIFO
// Contents: destination codes DEST_A..DEST_D, the statistics counter width
// STAT_W, and the saturating increment helper sat_inc.
package bus_dispatch_pkg;

  localparam logic [1:0] DEST_A = 2'd0;
  localparam logic [1:0] DEST_B = 2'd1;
  localparam logic [1:0] DEST_C = 2'd2;
  localparam logic [1:0] DEST_D = 2'd3;

  localparam int STAT_W = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/bus_dispatch_mem.sv
// rtl/bus_dispatch_mem.sv - DEPTH x WIDTH storage, one write port, one async read port
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write word
//   raddr  in   read address
//   rdata  out  read word, combinational from raddr
// Contents are not reset; the owner masks stale data.
module bus_dispatch_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_dispatch_fifo.sv
// rtl/bus_dispatch_fifo.sv - first-word-fall-through FIFO feeding a 4-way destination demux
// Optional feature macro: BUS_DISPATCH_STATS_EN adds per-destination pop counters.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  producer handshake; in_data word, in_dest destination
//   Y, SEL             head word and destination (zero while empty)
//   out_valid/out_ready consumer handshake
//   level              number of stored entries
//   cnt_a..cnt_d       saturating pop counters per destination (macro builds only)
module bus_dispatch_fifo
  import bus_dispatch_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BUS_WIDTH-1:0]   in_data,
  input  logic [1:0]             in_dest,
  output logic [BUS_WIDTH-1:0]   Y,
  output logic [1:0]             SEL,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level
`ifdef BUS_DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0]      cnt_a,
  output logic [STAT_W-1:0]      cnt_b,
  output logic [STAT_W-1:0]      cnt_c,
  output logic [STAT_W-1:0]      cnt_d
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int EW    = BUS_WIDTH + 2;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [EW-1:0]    head_word;
  logic             push, pop;

  // Handshake flags depend only on the registered level, never on inputs.
  assign in_ready  = (level_q < LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;

  // Entry layout is {dest, data}.
  bus_dispatch_mem #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push && !rst),
    .waddr(wr_ptr_q),
    .wdata({in_dest, in_data}),
    .raddr(rd_ptr_q),
    .rdata(head_word)
  );

  // Masking keeps the demux on destination A with zero data while empty.
  assign Y   = out_valid ? head_word[BUS_WIDTH-1:0] : '0;
  assign SEL = out_valid ? head_word[EW-1:BUS_WIDTH] : DEST_A;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers are exactly AW bits wide, so the increment wraps on its own.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

`ifdef BUS_DISPATCH_STATS_EN
  logic [STAT_W-1:0] cnt_a_q, cnt_a_d;
  logic [STAT_W-1:0] cnt_b_q, cnt_b_d;
  logic [STAT_W-1:0] cnt_c_q, cnt_c_d;
  logic [STAT_W-1:0] cnt_d_q, cnt_d_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    cnt_d_d = cnt_d_q;
    if (pop) begin
      case (SEL)
        DEST_A:  cnt_a_d = sat_inc(cnt_a_q);
        DEST_B:  cnt_b_d = sat_inc(cnt_b_q);
        DEST_C:  cnt_c_d = sat_inc(cnt_c_q);
        default: cnt_d_d = sat_inc(cnt_d_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
      cnt_d_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
  assign cnt_c = cnt_c_q;
  assign cnt_d = cnt_d_q;
`endif

endmodule

// File: tb/tb_bus_dispatch_fifo.sv
// tb/tb_bus_dispatch_fifo.sv - self-checking bench for bus_dispatch_fifo against a queue model
module tb_bus_dispatch_fifo;

  localparam int BW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic [1:0]    in_dest = '0;
  logic [BW-1:0] Y;
  logic [1:0]    SEL;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    level;
`ifdef BUS_DISPATCH_STATS_EN
  logic [15:0]   cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  bus_dispatch_fifo #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .Y        (Y),
    .SEL      (SEL),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level)
`ifdef BUS_DISPATCH_STATS_EN
    ,
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .cnt_c    (cnt_c),
    .cnt_d    (cnt_d)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model: an ordered queue of {dest, data} plus per-destination pop counts.
  logic [9:0]  mq[$];
  logic [15:0] mcnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance the model by the same rules.
  task automatic step(input logic r, input logic iv, input logic [7:0] d,
                      input logic [1:0] ds, input logic ordy);
    bit pu, po;
    rst = r; in_valid = iv; in_data = d; in_dest = ds; out_ready = ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = 16'h0;
    end else begin
      pu = iv && (mq.size() < DEPTH);
      po = ordy && (mq.size() > 0);
      if (po) begin
        if (mcnt[mq[0][9:8]] != 16'hFFFF) mcnt[mq[0][9:8]]++;
        void'(mq.pop_front());
      end
      if (pu) mq.push_back({ds, d});
    end
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("Y", 32'(Y), (mq.size() > 0) ? 32'(mq[0][7:0]) : 32'h0);
      chk("SEL", 32'(SEL), (mq.size() > 0) ? 32'(mq[0][9:8]) : 32'h0);
`ifdef BUS_DISPATCH_STATS_EN
      chk("cnt_a", 32'(cnt_a), 32'(mcnt[0]));
      chk("cnt_b", 32'(cnt_b), 32'(mcnt[1]));
      chk("cnt_c", 32'(cnt_c), 32'(mcnt[2]));
      chk("cnt_d", 32'(cnt_d), 32'(mcnt[3]));
`endif
    end
  end

  logic [7:0] seq_d [4];
  logic [1:0] seq_s [4];

  initial begin
    seq_d[0] = 8'h11; seq_d[1] = 8'h22; seq_d[2] = 8'h33; seq_d[3] = 8'h44;
    seq_s[0] = 2'd0;  seq_s[1] = 2'd1;  seq_s[2] = 2'd2;  seq_s[3] = 2'd3;

    step(1, 0, 8'h00, 2'd0, 0);
    step(1, 0, 8'h00, 2'd0, 0);
    chk_on = 1'b1;
    step(0, 0, 8'h00, 2'd0, 0);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_Y", 32'(Y), 32'd0);
    chk("idle_SEL", 32'(SEL), 32'd0);

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) step(0, 1, seq_d[i], seq_s[i], 0);
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_Y", 32'(Y), 32'h11);
    chk("full_SEL", 32'(SEL), 32'd0);
    // Offers while full must be dropped.
    step(0, 1, 8'hFF, 2'd3, 0);
    step(0, 1, 8'hFF, 2'd3, 0);
    chk("full_hold_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_Y", 32'(Y), 32'(seq_d[i]));
      chk("drain_SEL", 32'(SEL), 32'(seq_s[i]));
      step(0, 0, 8'h00, 2'd0, 1);
    end
    chk("drained_out_valid", 32'(out_valid), 32'd0);
    step(0, 0, 8'h00, 2'd0, 1);
    chk("no_underflow", 32'(level), 32'd0);

    // Steady push+pop at level 2 across pointer wrap.
    step(0, 1, 8'hA0, 2'd1, 0);
    step(0, 1, 8'hA1, 2'd2, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_Y", 32'(Y), (i == 0) ? 32'hA0 : (i == 1) ? 32'hA1 : 32'(8'h50 + i - 2));
      step(0, 1, 8'(8'h50 + i), 2'(i), 1);
      chk("stream_level", 32'(level), 32'd2);
    end

    // Reset with three entries; push in the reset cycle is discarded.
    step(0, 1, 8'h77, 2'd3, 1);
    step(0, 1, 8'h78, 2'd3, 0);
    chk("pre_rst_level", 32'(level), 32'd3);
    step(1, 1, 8'h99, 2'd1, 1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_Y", 32'(Y), 32'd0);
    step(0, 1, 8'h5A, 2'd2, 0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_Y", 32'(Y), 32'h5A);
    chk("post_rst_SEL", 32'(SEL), 32'd2);

`ifdef BUS_DISPATCH_STATS_EN
    step(1, 0, 8'h00, 2'd0, 0);
    step(0, 1, 8'h01, 2'd2, 0);
    step(0, 1, 8'h02, 2'd2, 0);
    step(0, 1, 8'h03, 2'd2, 0);
    step(0, 1, 8'h04, 2'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 2'd0, 1);
    chk("stat_cnt_c", 32'(cnt_c), 32'd3);
    chk("stat_cnt_a", 32'(cnt_a), 32'd1);
    chk("stat_cnt_b", 32'(cnt_b), 32'd0);
    chk("stat_cnt_d", 32'(cnt_d), 32'd0);
    dut.cnt_a_q = 16'hFFFF;
    mcnt[0] = 16'hFFFF;
    step(0, 1, 8'h05, 2'd0, 0);
    step(0, 0, 8'h00, 2'd0, 1);
    chk("stat_sat", 32'(cnt_a), 32'hFFFF);
`endif

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 2'($urandom), ($urandom_range(0, 2) != 0));
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
